// File: rtl/mac_dot_product_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer and other multiply_accumulate users.
package mac_dot_product_sequencer_pkg;

    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_ACC_W       = 32;
    localparam int unsigned DEF_MAX_LEN     = 256;
    localparam int unsigned DEF_LEN_W       = 9;
    localparam int unsigned DEF_MAC_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mac_dot_product_sequencer.sv
// Frames an operand stream into MAC vectors, waits out the MAC pipeline and
// presents each dot product on a valid/ready result port.
module mac_dot_product_sequencer
    import mac_dot_product_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ACC_W       = DEF_ACC_W,
    parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned MAC_LATENCY = DEF_MAC_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] mac_in_a,
    output logic [DATA_W-1:0] mac_in_b,
    output logic              mac_enable,
    output logic              mac_clear,
    input  logic [ACC_W-1:0]  mac_out,
    output logic [ACC_W-1:0]  result_data,
    output logic [LEN_W-1:0]  result_len,
    output logic              result_trunc,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    localparam int unsigned DRAIN_W    = (MAC_LATENCY > 2) ? $clog2(MAC_LATENCY) : 1;
    localparam int unsigned DRAIN_LOAD = (MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0;

    seq_state_e         state;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   beat_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               trunc_q;

    // Handshake and MAC controls decode straight from the state register.
    assign in_ready   = (state == ST_ACCUM);
    assign mac_clear  = (state == ST_CLEAR);
    assign mac_enable = in_valid & in_ready;
    assign mac_in_a   = in_a;
    assign mac_in_b   = in_b;
    assign busy       = (state != ST_ACCUM) || (beat_cnt != '0);
    assign beat_next  = beat_cnt + LEN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_CLEAR;
            beat_cnt     <= '0;
            drain_cnt    <= '0;
            trunc_q      <= 1'b0;
            result_data  <= '0;
            result_len   <= '0;
            result_trunc <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        beat_cnt <= beat_next;
                        // in_last wins over the length cap when both coincide
                        if (in_last || (beat_next == LEN_W'(MAX_LEN))) begin
                            trunc_q   <= ~in_last;
                            drain_cnt <= DRAIN_W'(DRAIN_LOAD);
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        result_data  <= mac_out;
                        result_len   <= beat_cnt;
                        result_trunc <= trunc_q;
                        result_valid <= 1'b1;
                        state        <= ST_RESULT;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        beat_cnt     <= '0;
                        state        <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_product_sequencer.sv
// Directed bench: sequencer plus a 3-stage behavioural MAC (register, multiply, accumulate).
module tb_mac_dot_product_sequencer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LEN_W  = 3;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_a, in_b;
    logic              in_valid, in_last, in_ready;
    logic [DATA_W-1:0] mac_in_a, mac_in_b;
    logic              mac_enable, mac_clear;
    logic [ACC_W-1:0]  mac_out;
    logic [ACC_W-1:0]  result_data;
    logic [LEN_W-1:0]  result_len;
    logic              result_trunc, result_valid, result_ready, busy;

    int errors = 0;
    int checks = 0;

    mac_dot_product_sequencer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_LEN(4), .LEN_W(LEN_W), .MAC_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .mac_in_a(mac_in_a), .mac_in_b(mac_in_b),
        .mac_enable(mac_enable), .mac_clear(mac_clear), .mac_out(mac_out),
        .result_data(result_data), .result_len(result_len), .result_trunc(result_trunc),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: sample at E0, multiply at E0+1, accumulate at E0+2.
    logic              s1_v, s2_v;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [ACC_W-1:0]  s2_p, acc;
    assign mac_out = acc;
    always @(posedge clk) begin
        if (rst || mac_clear) begin
            s1_v <= 1'b0; s2_v <= 1'b0; acc <= '0;
        end else begin
            s1_v <= mac_enable; s1_a <= mac_in_a; s1_b <= mac_in_b;
            s2_v <= s1_v;
            s2_p <= ACC_W'(s1_a) * ACC_W'(s1_b);
            if (s2_v) acc <= acc + s2_p;
        end
    end

    // Holds a beat until accepted; returns just after the accepting edge.
    task automatic send_beat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic last);
        logic accepted;
        accepted = 1'b0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            accepted = in_ready;
            @(posedge clk); #1;
            if (accepted) break;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!accepted) begin
            errors++;
            $display("FAIL send_beat timeout: in_ready stayed %0b, required 1", in_ready);
        end
    endtask

    task automatic wait_result(output logic got);
        got = result_valid;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            got = result_valid;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_a = 16'h1234; in_b = 16'h0005;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || mac_enable !== 1'b0 || mac_clear !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b en=%b clr=%b busy=%b, required 0 0 1 1",
                     in_ready, mac_enable, mac_clear, busy);
        end
        checks++;
        if (result_valid !== 1'b0 || result_data !== 32'h0 || result_len !== 3'd0 ||
            result_trunc !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: valid=%b data=%h len=%0d trunc=%b, required 0 0 0 0",
                     result_valid, result_data, result_len, result_trunc);
        end
        checks++;
        if (mac_in_a !== 16'h1234 || mac_in_b !== 16'h0005) begin
            errors++;
            $display("FAIL mac_passthru: a=%h b=%h, required 1234 0005", mac_in_a, mac_in_b);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic got;
        result_ready = 1'b1;
        send_beat(16'd2, 16'd3, 1'b0);
        send_beat(16'd4, 16'd5, 1'b1);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain_ctrl: ready=%b busy=%b valid=%b, required 0 1 0",
                     in_ready, busy, result_valid);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: valid=%b at E0+2, required 0", result_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: valid=%b at E0+3, required 1", result_valid);
        end
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd26 || result_len !== 3'd2 || result_trunc !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: valid=%b data=%0d len=%0d trunc=%b, required 1 26 2 0",
                     got, result_data, result_len, result_trunc);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || in_ready !== 1'b0 || mac_clear !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: valid=%b ready=%b clr=%b, required 0 0 1",
                     result_valid, in_ready, mac_clear);
        end
    endtask

    task automatic test_back_to_back;
        logic got;
        result_ready = 1'b1;
        send_beat(16'd1, 16'd1, 1'b0);
        send_beat(16'd1, 16'd1, 1'b0);
        send_beat(16'd1, 16'd1, 1'b1);
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd3 || result_len !== 3'd3 || result_trunc !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: valid=%b data=%0d len=%0d trunc=%b, required 1 3 3 0",
                     got, result_data, result_len, result_trunc);
        end
        send_beat(16'd7, 16'd8, 1'b1);
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd56 || result_len !== 3'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b data=%0d len=%0d ready=%b, required 1 56 1 0",
                     got, result_data, result_len, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold;
        logic got;
        int   bad;
        result_ready = 1'b0;
        send_beat(16'hFFFF, 16'hFFFF, 1'b0);
        send_beat(16'hFFFF, 16'hFFFF, 1'b1);
        wait_result(got);
        in_a = 16'd9; in_b = 16'd9; in_last = 1'b1; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (result_valid !== 1'b1 || result_data !== 32'hFFFC0002 || in_ready !== 1'b0 ||
                mac_enable !== 1'b0)
                bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (!got || bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got=%b bad_cycles=%0d data=%h, required 1 0 fffc0002",
                     got, bad, result_data);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b, required 0", result_valid);
        end
        send_beat(16'd9, 16'd9, 1'b1);
        result_ready = 1'b0;
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd81 || result_len !== 3'd1) begin
            errors++;
            $display("FAIL hold_next: valid=%b data=%0d len=%0d, required 1 81 1",
                     got, result_data, result_len);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_trunc;
        logic got;
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(16'd1, 16'd2, 1'b0);
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd8 || result_len !== 3'd4 || result_trunc !== 1'b1) begin
            errors++;
            $display("FAIL trunc_result: valid=%b data=%0d len=%0d trunc=%b, required 1 8 4 1",
                     got, result_data, result_len, result_trunc);
        end
        result_ready = 1'b1;
        send_beat(16'd1, 16'd2, 1'b0);
        send_beat(16'd1, 16'd2, 1'b0);
        send_beat(16'd0, 16'd0, 1'b1);
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd4 || result_len !== 3'd3 || result_trunc !== 1'b0) begin
            errors++;
            $display("FAIL trunc_next: valid=%b data=%0d len=%0d trunc=%b, required 1 4 3 0",
                     got, result_data, result_len, result_trunc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic got;
        result_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(16'd5, 16'd5, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || mac_clear !== 1'b1 || busy !== 1'b1 || result_len !== 3'd0 ||
            result_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: ready=%b clr=%b busy=%b len=%0d data=%0d, required 0 1 1 0 0",
                     in_ready, mac_clear, busy, result_len, result_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_beat(16'd3, 16'd3, 1'b1);
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd9 || result_len !== 3'd1) begin
            errors++;
            $display("FAIL rst_next: valid=%b data=%0d len=%0d, required 1 9 1",
                     got, result_data, result_len);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles;
        logic got;
        result_ready = 1'b1;
        send_beat(16'd1, 16'd2, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (mac_enable !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bubble_gap: en=%b ready=%b busy=%b, required 0 1 1",
                     mac_enable, in_ready, busy);
        end
        send_beat(16'd3, 16'd4, 1'b0);
        @(posedge clk); #1;
        send_beat(16'd5, 16'd6, 1'b1);
        wait_result(got);
        checks++;
        if (!got || result_data !== 32'd44 || result_len !== 3'd3) begin
            errors++;
            $display("FAIL bubble_result: valid=%b data=%0d len=%0d, required 1 44 3",
                     got, result_data, result_len);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_trunc();
        test_reset_mid();
        test_bubbles();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
